// File: rtl/i2s_pkg.sv
// Shared types for the I2S receiver: FSM states, channel tags and the default sample width.
package i2s_pkg;

    localparam int unsigned I2S_SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        HOLD
    } i2s_rx_state_t;

    typedef enum logic {
        CH_LEFT,
        CH_RIGHT
    } i2s_ch_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses of the synchronised value.
module i2s_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdin with CLK and emits one {left,right} pair per frame.
// Optional I2S_RX_PEAK_EN adds per-channel peak magnitude outputs cleared on each handshake.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = I2S_SAMPLE_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdin,
    input  logic                enable,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
`ifdef I2S_RX_PEAK_EN
    ,
    output logic [SAMPLE_W-1:0] peak_left,
    output logic [SAMPLE_W-1:0] peak_right
`endif
);

    localparam int unsigned         CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0]    FULL  = CNT_W'(SAMPLE_W);

    logic sclk_s, sclk_rise, sclk_fall_unused;
    logic lr_s_unused, lr_rise, lr_fall;
    logic sd_s, sd_rise_unused, sd_fall_unused;

    i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .CLK(CLK), .RESET(RESET), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .CLK(CLK), .RESET(RESET), .din(lrclk),
        .dout(lr_s_unused), .rise(lr_rise), .fall(lr_fall)
    );

    i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdin (
        .CLK(CLK), .RESET(RESET), .din(sdin),
        .dout(sd_s), .rise(sd_rise_unused), .fall(sd_fall_unused)
    );

    i2s_rx_state_t       state, state_nxt;
    logic [SAMPLE_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [SAMPLE_W-1:0] left_hold, left_hold_nxt;
    logic [SAMPLE_W-1:0] slot_word;
    i2s_ch_t             ch_done;
    logic                pair_done;
    logic                handshake;
    logic                load;

    // Short slots land MSB-aligned; a count of zero shifts everything out.
    function automatic logic [SAMPLE_W-1:0] align(input logic [SAMPLE_W-1:0] v,
                                                  input logic [CNT_W-1:0]    n);
        return v << (FULL - n);
    endfunction

    assign slot_word = align(shreg, bit_cnt);
    assign handshake = out_valid & out_ready;
    assign load      = pair_done & (~out_valid | out_ready);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            left_hold <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            left_hold <= left_hold_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        left_hold_nxt = left_hold;
        ch_done       = CH_LEFT;
        pair_done     = 1'b0;
        if (!enable) begin
            state_nxt   = IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
        end else if (state == IDLE) begin
            if (lr_fall) begin
                state_nxt   = SKIP;
                shreg_nxt   = '0;
                bit_cnt_nxt = '0;
            end
        end else if (lr_rise || lr_fall) begin
            // A rising word select ends the left slot, a falling one ends the right slot.
            ch_done = lr_rise ? CH_LEFT : CH_RIGHT;
            if (ch_done == CH_LEFT) begin
                left_hold_nxt = slot_word;
            end else begin
                pair_done = 1'b1;
            end
            state_nxt   = SKIP;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
        end else if (sclk_rise) begin
            case (state)
                SKIP: begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                end
                SHIFT: begin
                    shreg_nxt   = {shreg[SAMPLE_W-2:0], sd_s};
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == FULL - CNT_W'(1)) begin
                        state_nxt = HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            out_left  <= left_hold;
            out_right <= slot_word;
            out_valid <= 1'b1;
        end else begin
            if (pair_done) begin
                overrun <= 1'b1;
            end
            if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_PEAK_EN
    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MAX_POS  = {1'b0, {(SAMPLE_W-1){1'b1}}};

    function automatic logic [SAMPLE_W-1:0] mag(input logic [SAMPLE_W-1:0] v);
        if (!v[SAMPLE_W-1]) return v;
        if (v == MOST_NEG) return MAX_POS;
        return -v;
    endfunction

    logic [SAMPLE_W-1:0] peak_l_base, peak_r_base, mag_l, mag_r;

    assign peak_l_base = handshake ? '0 : peak_left;
    assign peak_r_base = handshake ? '0 : peak_right;
    assign mag_l       = mag(left_hold);
    assign mag_r       = mag(slot_word);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (pair_done) begin
            peak_left  <= (mag_l > peak_l_base) ? mag_l : peak_l_base;
            peak_right <= (mag_r > peak_r_base) ? mag_r : peak_r_base;
        end else if (handshake) begin
            peak_left  <= '0;
            peak_right <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed self-checking bench for i2s_rx; define I2S_RX_PEAK_EN to also exercise the peak outputs.
module tb_i2s_rx;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        sclk, lrclk, sdin, enable, out_ready;
    logic [15:0] out_left, out_right;
    logic        out_valid, overrun;
`ifdef I2S_RX_PEAK_EN
    logic [15:0] peak_left, peak_right;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    i2s_rx #(.SAMPLE_W(16), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
        .enable(enable), .out_left(out_left), .out_right(out_right),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
`ifdef I2S_RX_PEAK_EN
        , .peak_left(peak_left), .peak_right(peak_right)
`endif
    );

    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One sclk period: falling edge drives lrclk/sdin, rising edge half a period later.
    task automatic sbit(input logic lr, input logic d);
        @(negedge CLK);
        sclk  = 1'b0;
        lrclk = lr;
        sdin  = d;
        repeat (16) @(negedge CLK);
        sclk = 1'b1;
        repeat (16) @(negedge CLK);
    endtask

    // Slot = one delay bit (inverted MSB, so a slip is visible) then n data bits MSB first.
    task automatic send_slot(input logic lr, input logic [31:0] w, input int unsigned n);
        sbit(lr, ~w[31]);
        for (int unsigned j = 0; j < n; j++) sbit(lr, w[31-j]);
    endtask

    task automatic frame(input logic [31:0] lw, input logic [31:0] rw, input int unsigned n);
        send_slot(1'b0, lw, n);
        send_slot(1'b1, rw, n);
    endtask

    // Final lrclk fall completes the pair; then park in IDLE with lrclk high.
    task automatic end_stream(input bit chk_lat);
        @(negedge CLK);
        sclk  = 1'b0;
        lrclk = 1'b0;
        sdin  = 1'b0;
        if (chk_lat) begin
            repeat (2) @(posedge CLK);
            #1 check("lat_early", 32'(out_valid), 32'd0);
            @(posedge CLK);
            #1 check("lat_valid", 32'(out_valid), 32'd1);
        end
        repeat (16) @(negedge CLK);
        sclk = 1'b1;
        repeat (16) @(negedge CLK);
        enable = 1'b0;
        sbit(1'b1, 1'b0);
        sbit(1'b1, 1'b0);
        enable = 1'b1;
    endtask

    task automatic accept(input string tag);
        @(negedge CLK);
        out_ready = 1'b1;
        @(posedge CLK);
        #1 check(tag, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        RESET     = 1'b1;
        sclk      = 1'b1;
        lrclk     = 1'b1;
        sdin      = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b0;
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_left",    32'(out_left),  32'd0);
        check("rst_right",   32'(out_right), 32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        repeat (4) @(negedge CLK);

        // Basic pair, 32-bit slots, trailing slot bits ignored
        frame(32'h8001_FFFF, 32'h7FFE_FFFF, 31);
        end_stream(1'b1);
        check("t1_left",    32'(out_left),  32'h8001);
        check("t1_right",   32'(out_right), 32'h7FFE);
        check("t1_overrun", 32'(overrun),   32'd0);
        accept("t1_hs");

        // Short 12-bit slots, zero-filled LSBs
        frame(32'hABC0_0000, 32'h5A50_0000, 12);
        end_stream(1'b0);
        check("t2_left",  32'(out_left),  32'hABC0);
        check("t2_right", 32'(out_right), 32'h5A50);
        accept("t2_hs");

        // Backpressure: first pair held, later pairs dropped
        frame(32'h1234_0000, 32'h5678_0000, 31);
        frame(32'h1111_0000, 32'h2222_0000, 31);
        check("t3_valid1",   32'(out_valid), 32'd1);
        check("t3_left1",    32'(out_left),  32'h1234);
        check("t3_overrun1", 32'(overrun),   32'd0);
        frame(32'h3333_0000, 32'h4444_0000, 31);
        check("t3_left2",    32'(out_left),  32'h1234);
        check("t3_right2",   32'(out_right), 32'h5678);
        check("t3_overrun2", 32'(overrun),   32'd1);
        end_stream(1'b0);
        check("t3_left3",    32'(out_left),  32'h1234);
        accept("t3_hs");

        // Reset in the middle of a left slot
        frame(32'hCAFE_0000, 32'hBEEF_0000, 31);
        sbit(1'b0, 1'b1);
        for (int unsigned j = 0; j < 8; j++) sbit(1'b0, 1'b1);
        check("t4_pre_valid", 32'(out_valid), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("t4_valid",   32'(out_valid), 32'd0);
        check("t4_left",    32'(out_left),  32'd0);
        check("t4_right",   32'(out_right), 32'd0);
        check("t4_overrun", 32'(overrun),   32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        for (int unsigned j = 0; j < 8; j++) sbit(1'b0, 1'b0);
        send_slot(1'b1, 32'hFFFF_FFFF, 31);
        frame(32'h0F0F_0000, 32'hF0F0_0000, 31);
        check("t4_nopair", 32'(out_valid), 32'd0);
        end_stream(1'b0);
        check("t4_left2",  32'(out_left),  32'h0F0F);
        check("t4_right2", 32'(out_right), 32'hF0F0);
        accept("t4_hs");

        // enable dropped mid right slot: that frame is discarded
        send_slot(1'b0, 32'h9999_0000, 31);
        sbit(1'b1, 1'b1);
        for (int unsigned j = 0; j < 5; j++) sbit(1'b1, 1'b0);
        enable = 1'b0;
        sbit(1'b1, 1'b1);
        sbit(1'b1, 1'b0);
        enable = 1'b1;
        for (int unsigned j = 5; j < 31; j++) sbit(1'b1, 1'b1);
        frame(32'hA5A5_0000, 32'h3C3C_0000, 31);
        check("t5_nopair", 32'(out_valid), 32'd0);
        end_stream(1'b0);
        check("t5_left",  32'(out_left),  32'hA5A5);
        check("t5_right", 32'(out_right), 32'h3C3C);
        accept("t5_hs");

`ifdef I2S_RX_PEAK_EN
        frame(32'h8000_0000, 32'hFFF0_0000, 31);
        end_stream(1'b0);
        check("t6_peak_l", 32'(peak_left),  32'h7FFF);
        check("t6_peak_r", 32'(peak_right), 32'h0010);
        accept("t6_hs");
        check("t6_clr_l", 32'(peak_left),  32'h0000);
        check("t6_clr_r", 32'(peak_right), 32'h0000);
        frame(32'h0010_0000, 32'h0003_0000, 31);
        end_stream(1'b0);
        check("t6_peak_l2", 32'(peak_left),  32'h0010);
        check("t6_peak_r2", 32'(peak_right), 32'h0003);
        accept("t6_hs2");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
